// File: rtl/md_ctrl_pkg.sv
// Shared encodings and constants for the mul/div sequencing controller.
// Holds the FSM encoding, decode constants and the exception status words.
package md_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

  localparam logic [4:0] OP_RTYPE  = 5'b00000;
  localparam logic [4:0] ALUOP_MUL = 5'b00110;
  localparam logic [4:0] ALUOP_DIV = 5'b00111;

  localparam int MUL_EXC_CODE_DEF = 4;
  localparam int DIV_EXC_CODE_DEF = 5;
  localparam int RSTATUS_REG_DEF  = 30;

  // Status word written to $rstatus when the unit raises an exception.
  function automatic logic [31:0] exc_word(input logic is_div,
                                           input int   mul_code,
                                           input int   div_code);
    return is_div ? 32'(div_code) : 32'(mul_code);
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Wait-state counter: synchronous clear, count enable, terminal-count flag.
// tc is high while the count sits at TIMEOUT_CYCLES-1.
module md_wait_counter #(
  parameter int CNT_W          = 6,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/md_seq_ctrl.sv
// Sequencer for the iterative mul/div unit: stalls the front end, strobes the
// unit, waits for the result and arbitrates for the regfile write port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no operation; accepts md_req unless flushed
// ST_ISSUE | one-cycle start strobe to the unit, wait counter cleared
// ST_WAIT  | waiting for md_resultRDY, bounded by TIMEOUT_CYCLES
// ST_WB    | holding wb_rd/wb_data and requesting the write port
module md_seq_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6,
  parameter int RSTATUS_REG    = RSTATUS_REG_DEF,
  parameter int MUL_EXC_CODE   = MUL_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE   = DIV_EXC_CODE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        md_req,
  input  logic        md_is_div,
  input  logic [4:0]  md_rd,
  input  logic        flush,
  output logic        stall,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        wb_req,
  input  logic        wb_grant,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout_err
);

  md_state_e   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_req_q, wb_req_d;
  logic        tmo_q, tmo_d;
  logic        cnt_clr, cnt_en, cnt_tc;

  md_wait_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_req_d  = wb_req_q;
    tmo_d     = tmo_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (md_req && !flush) begin
          rd_d     = md_rd;
          is_div_d = md_is_div;
          state_d  = ST_ISSUE;
        end
      end

      // The strobe fires even when flushed; the orphaned result lands in IDLE.
      ST_ISSUE: begin
        cnt_clr = 1'b1;
        state_d = flush ? ST_IDLE : ST_WAIT;
      end

      ST_WAIT: begin
        cnt_en = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (md_resultRDY) begin
          if (md_exception) begin
            wb_rd_d   = 5'(RSTATUS_REG);
            wb_data_d = exc_word(is_div_q, MUL_EXC_CODE, DIV_EXC_CODE);
            wb_req_d  = 1'b1;
            state_d   = ST_WB;
          end else if (rd_q != 5'd0) begin
            wb_rd_d   = rd_q;
            wb_data_d = md_result;
            wb_req_d  = 1'b1;
            state_d   = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_tc) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_WB: begin
        if (wb_grant) begin
          wb_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_req_q  <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_req_q  <= wb_req_d;
      tmo_q     <= tmo_d;
    end
  end

  // Stall drops in the grant cycle so the instruction leaves X on that edge.
  assign stall = ((state_q == ST_IDLE) && md_req && !flush) ||
                 (state_q == ST_ISSUE) ||
                 (state_q == ST_WAIT) ||
                 ((state_q == ST_WB) && !wb_grant);

  assign ctrl_MULT   = (state_q == ST_ISSUE) && !is_div_q;
  assign ctrl_DIV    = (state_q == ST_ISSUE) && is_div_q;
  assign busy        = (state_q != ST_IDLE);
  assign wb_req      = wb_req_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Scoreboard bench for md_seq_ctrl: stimulus pushes expected regfile writes,
// a negedge monitor pops them when the write port commits.
module tb_md_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        md_req, md_is_div, flush;
  logic [4:0]  md_rd;
  logic        stall, ctrl_MULT, ctrl_DIV;
  logic        md_resultRDY, md_exception;
  logic [31:0] md_result;
  logic        wb_req, wb_grant;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, timeout_err;

  md_seq_ctrl dut (
    .clock(clock), .reset(reset), .md_req(md_req), .md_is_div(md_is_div),
    .md_rd(md_rd), .flush(flush), .stall(stall), .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV), .md_resultRDY(md_resultRDY), .md_result(md_result),
    .md_exception(md_exception), .wb_req(wb_req), .wb_grant(wb_grant),
    .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  strobe_cyc[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_mult  = 0;
  int  n_div   = 0;
  int  cyc     = 0;
  logic tmo_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (ctrl_MULT) begin n_mult++; strobe_cyc.push_back(cyc); end
    if (ctrl_DIV)  begin n_div++;  strobe_cyc.push_back(cyc); end
    if (wb_req && wb_grant) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: write rd=%0d data=0x%0h, expected no write", wb_rd, wb_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
      end
    end
  end

  // Reference outcome of a completed operation, from the architectural rules.
  function automatic bit expect_write(input bit is_div, input logic [4:0] rd, input bit exc,
                                      input logic [31:0] res, output wr_t w);
    w.rd = 5'd0; w.data = 32'd0;
    if (exc) begin
      w.rd = 5'd30; w.data = is_div ? 32'd5 : 32'd4;
      return 1'b1;
    end
    if (rd != 5'd0) begin
      w.rd = rd; w.data = res;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Accept an op in IDLE and advance to the first WAIT cycle.
  task automatic start_op(input bit is_div, input logic [4:0] rd);
    md_req = 1'b1; md_is_div = is_div; md_rd = rd;
    #1 chk("stall_on_req", stall, 1'b1);
    step();
    md_req = 1'b0; md_is_div = 1'($urandom); md_rd = 5'($urandom);
    #1;
    chk("strobe_mul", ctrl_MULT, !is_div);
    chk("strobe_div", ctrl_DIV, is_div);
    chk("stall_issue", stall, 1'b1);
    step();
  endtask

  task automatic run_op(input bit is_div, input logic [4:0] rd, input int lat, input bit exc,
                        input logic [31:0] res, input int gdel);
    int  mc, dc;
    wr_t w;
    bit  has_wr;
    mc = n_mult; dc = n_div;
    start_op(is_div, rd);
    for (int i = 1; i < lat; i++) begin
      chk("wait_stall", stall, 1'b1);
      wb_grant = 1'($urandom);
      step();
    end
    wb_grant = 1'b0;
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    has_wr = expect_write(is_div, rd, exc, res, w);
    if (has_wr) sb_q.push_back(w);
    step();
    md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'($urandom);
    #1;
    if (!has_wr) begin
      chk("no_wb_req", wb_req, 1'b0);
      chk("idle_no_wr", busy, 1'b0);
    end else begin
      chk("wb_req_on", wb_req, 1'b1);
      for (int i = 0; i < gdel; i++) begin
        flush = 1'($urandom);
        #1;
        chk("wb_hold_stall", stall, 1'b1);
        chk("wb_hold_req", wb_req, 1'b1);
        chk("wb_hold_rd", {27'd0, wb_rd}, {27'd0, w.rd});
        chk("wb_hold_data", wb_data, w.data);
        step();
      end
      flush = 1'b0;
      wb_grant = 1'b1;
      #1 chk("stall_grant", stall, 1'b0);
      step();
      wb_grant = 1'b0;
      #1;
      chk("busy_after_grant", busy, 1'b0);
      chk("wb_req_dropped", wb_req, 1'b0);
    end
    chk("mul_strobes", n_mult - mc, is_div ? 0 : 1);
    chk("div_strobes", n_div - dc, is_div ? 1 : 0);
    chk("timeout_sticky", timeout_err, tmo_exp);
  endtask

  task automatic flush_wait_op(input int w);
    start_op(1'($urandom), 5'($urandom_range(1, 31)));
    for (int i = 0; i < w; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_idle", busy, 1'b0);
    chk("flush_stall", stall, 1'b0);
    md_resultRDY = 1'b1; md_exception = 1'($urandom); md_result = $urandom;
    step();
    md_resultRDY = 1'b0;
    #1;
    chk("stale_rdy_busy", busy, 1'b0);
    chk("stale_rdy_wbreq", wb_req, 1'b0);
    chk("flush_tmo", timeout_err, tmo_exp);
  endtask

  task automatic timeout_op();
    start_op(1'b0, 5'd9);
    for (int i = 0; i < 39; i++) step();
    chk("tmo_early", timeout_err, 1'b0);
    chk("tmo_early_busy", busy, 1'b1);
    step();
    tmo_exp = 1'b1;
    chk("tmo_set", timeout_err, 1'b1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_stall", stall, 1'b0);
    chk("tmo_no_wb", wb_req, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("tmo_sticky", timeout_err, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sidx;
    reset = 1'b1; md_req = 1'b0; md_is_div = 1'b0; md_rd = 5'd0; flush = 1'b0;
    md_resultRDY = 1'b0; md_result = 32'd0; md_exception = 1'b0; wb_grant = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_wb_req", wb_req, 1'b0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_tmo", timeout_err, 1'b0);
    reset = 1'b0;
    step();

    run_op(1'b0, 5'd5, 10, 1'b0, 32'h0000_002A, 0);
    run_op(1'b1, 5'd7, 6, 1'b1, 32'hDEAD_BEEF, 0);
    run_op(1'b0, 5'd12, 3, 1'b1, 32'h1234_5678, 3);
    run_op(1'b0, 5'd0, 4, 1'b0, 32'h0000_0099, 0);
    flush_wait_op(2);
    // A stale result arriving in IDLE with md_req present must not disturb it.
    md_resultRDY = 1'b1; md_exception = 1'b0;
    md_req = 1'b1; md_is_div = 1'b0; md_rd = 5'd3; flush = 1'b1;
    #1 chk("req_flush_stall", stall, 1'b0);
    step();
    md_req = 1'b0; flush = 1'b0; md_resultRDY = 1'b0;
    #1 chk("req_flush_idle", busy, 1'b0);

    timeout_op();

    start_op(1'b1, 5'd11);
    repeat (3) step();
    reset = 1'b1;
    step();
    tmo_exp = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_mult", ctrl_MULT, 1'b0);
    chk("midrst_div", ctrl_DIV, 1'b0);
    chk("midrst_wb_req", wb_req, 1'b0);
    chk("midrst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    chk("midrst_tmo", timeout_err, 1'b0);
    reset = 1'b0;
    step();

    sidx = strobe_cyc.size();
    run_op(1'b0, 5'd21, 1, 1'b0, 32'hCAFE_0001, 0);
    run_op(1'b1, 5'd22, 1, 1'b0, 32'hCAFE_0002, 0);
    if (strobe_cyc.size() == sidx + 2)
      chk("b2b_spacing", strobe_cyc[sidx+1] - strobe_cyc[sidx], 4);
    else
      chk("b2b_strobe_count", strobe_cyc.size() - sidx, 2);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        flush_wait_op($urandom_range(0, 6));
      end else begin
        run_op(1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom_range(1, 12), ($urandom_range(0, 3) == 0), $urandom,
               $urandom_range(0, 3));
      end
    end

    repeat (2) step();
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_seq_ctrl.md
Name: md_seq_ctrl

Overview:
Sequencing controller for the iterative multiply/divide unit in the processor's execute stage. When the X stage holds a mul/div instruction, the block stalls the front of the pipeline and pulses the unit's start strobe. It then waits for the result-ready handshake and arbitrates for the shared register-file write port. Multiply-overflow and divide-by-zero exceptions are redirected as a status-code write to $rstatus.

Parameters:
TIMEOUT_CYCLES, 40, WAIT-state cycles before abandoning an operation
CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES
RSTATUS_REG, 30, register index written on exception
MUL_EXC_CODE, 4, value written to RSTATUS_REG on multiply overflow
DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide exception

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
md_req  in  1  X stage holds R-type mul (aluOp 00110) or div (aluOp 00111)
md_is_div  in  1  1=div, 0=mul; sampled with md_req
md_rd  in  5  destination register; sampled with md_req
flush  in  1  pipeline flush from control-flow redirect
stall  out  1  hold F/D/X pipeline registers
ctrl_MULT  out  1  one-cycle start pulse to the multdiv unit
ctrl_DIV  out  1  one-cycle start pulse to the multdiv unit
md_resultRDY  in  1  unit result valid; single-cycle pulse
md_result  in  32  unit result
md_exception  in  1  unit exception flag; qualified by md_resultRDY
wb_req  out  1  request for the shared regfile write port
wb_grant  in  1  write port granted this cycle; the write commits on this edge
wb_rd  out  5  write destination
wb_data  out  32  write data
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set when an operation times out

Behaviour:
- Reset (synchronous): state=IDLE; counter=0; ctrl_MULT, ctrl_DIV, wb_req, timeout_err=0; wb_rd=0; wb_data=0; latched rd/is_div=0. Reset overrides every other input in any state.
- States: IDLE, ISSUE, WAIT, WB. Use a 2-bit encoding.
- IDLE:
  - On md_req & !flush: latch md_rd and md_is_div, go to ISSUE.
  - md_req & flush: stay in IDLE.
  - md_resultRDY in IDLE (stale result) is ignored.
- ISSUE:
  - ctrl_MULT = !is_div, ctrl_DIV = is_div, for exactly one cycle. Both strobes are Moore outputs decoded from state.
  - Clear the counter, go to WAIT.
  - If flush: go to IDLE. The strobe still fires this cycle, and the resulting result is discarded.
- WAIT:
  - Counter increments by 1 each cycle.
  - If md_resultRDY:
    - md_exception=1: load wb_rd=RSTATUS_REG, wb_data=zero-extended (is_div ? DIV_EXC_CODE : MUL_EXC_CODE), go to WB.
    - md_exception=0 and rd!=0: load wb_rd=rd, wb_data=md_result, go to WB.
    - md_exception=0 and rd==0: go to IDLE with no write.
  - Else if counter==TIMEOUT_CYCLES-1: set timeout_err, go to IDLE with no write.
  - If md_resultRDY and the timeout coincide, md_resultRDY wins.
  - flush has priority over both: go to IDLE, no write, timeout_err unchanged.
- WB:
  - wb_req=1 (registered, asserted from the WB entry edge). wb_rd and wb_data are held stable while in WB.
  - On wb_grant: wb_req drops at the next edge, go to IDLE.
  - flush is ignored in WB because the instruction has already completed.
- stall (combinational) = (IDLE & md_req & !flush) | ISSUE | WAIT | (WB & !wb_grant).
  - Stall therefore rises in the same cycle md_req appears.
  - Stall falls in the grant cycle, so the mul/div instruction leaves X on that edge.
- Back-to-back mul/div: after returning to IDLE, a new md_req is accepted the next cycle. Minimum operation latency from md_req to stall release is 4 cycles when the unit is ready in 1 cycle and grant is immediate.
- timeout_err is cleared only by reset.

Decomposition:
- Shared package md_ctrl_pkg:
  - state encodings for IDLE/ISSUE/WAIT/WB
  - R-type opcode 00000 and aluOp codes MUL=00110, DIV=00111
  - exception codes 4 and 5
  - RSTATUS index 30
- One natural sub-module, md_wait_counter: CNT_W-bit counter with synchronous clear, enable, and a terminal-count output compared against TIMEOUT_CYCLES-1.

Test Plan:
1. Mul, no exception: md_req=1, is_div=0, rd=5. Expect:
   - stall=1 in the same cycle; ctrl_MULT pulses once at cycle+1.
   - md_resultRDY with md_result=0x0000002A 10 cycles later, then wb_req=1 with wb_rd=5, wb_data=0x2A.
   - On wb_grant, stall=0 in that cycle and busy=0 the next cycle.
2. Div by zero: is_div=1, rd=7, md_resultRDY & md_exception. Expect wb_rd=30, wb_data=0x00000005, ctrl_DIV pulsed once, ctrl_MULT never asserted.
3. Mul overflow plus delayed grant: exception on the mul. Expect wb_rd=30, wb_data=4; hold wb_grant=0 for 3 cycles and check wb_req, wb_rd, wb_data stable and stall=1 throughout; on grant, stall=0.
4. rd=0 and flush:
   - rd=0 mul with a normal result: no wb_req at any point, return to IDLE.
   - Separately, flush asserted in WAIT: IDLE next cycle, no wb_req, and a later md_resultRDY is ignored.
5. Timeout with TIMEOUT_CYCLES=40: never assert md_resultRDY. Expect timeout_err=1 exactly 40 WAIT cycles after entry, stall=0, no wb_req; timeout_err stays set until reset.
6. Reset mid-WAIT, then back-to-back: a synchronous reset pulse during WAIT gives all outputs 0 at the next edge. Then issue two consecutive mul/div ops with immediate RDY and grant; expect exactly one start strobe per op, 4-cycle spacing, correct wb_rd for each.
